// File: rtl/alu_core.sv
// alu_core: 8-bit accumulator-style ALU stage feeding the CPU shifter.
// Latches operands A/B from the internal bus, executes the selected op into t,
// and keeps the carry/zero flags. cf can also be loaded from the shifter.
// Optional feature macro: ALU_MUL_EN (op 111 = 9-cycle shift-add multiply,
// ph driven). Without it, op 111 is a single-cycle XOR and ph reads 8'h00.
module alu_core #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] bus_in,
    input  logic         lda,
    input  logic         ldb,
    input  logic [2:0]   op,
    input  logic         start,
    input  logic         shift_cf,
    input  logic         ld_cf,
    output logic [W-1:0] t,
    output logic [W-1:0] ph,
    output logic         busy,
    output logic         done,
    output logic         cf,
    output logic         zf
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_ADC = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_INC = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    state_t         state_q, state_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   t_q, t_d;
    logic           cf_q, cf_d;
    logic           zf_q, zf_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    // Completion bookkeeping: result to write into t and the carry it produces.
    logic [W:0]     res_s;
    logic           cf_new_s;
    logic           cmp_s;

`ifdef ALU_MUL_EN
    logic [W-1:0]   ph_q, ph_d;
    logic [W-1:0]   hi_q, hi_d;   // running partial product, high half
    logic [W-1:0]   lo_q, lo_d;   // multiplier bits shifting out, product low half shifting in
    logic [3:0]     cnt_q, cnt_d;
    logic [W:0]     sum_s;
`endif

    // Next-state, operand load, datapath result and flag update.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        t_d      = t_q;
        zf_d     = zf_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        res_s    = {(W+1){1'b0}};
        cf_new_s = cf_q;
        cmp_s    = 1'b0;
`ifdef ALU_MUL_EN
        ph_d     = ph_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        cnt_d    = cnt_q;
        sum_s    = {(W+1){1'b0}};
`endif

        case (state_q)
            ST_IDLE: begin
                if (lda) begin
                    a_d = bus_in;
                end else begin
                    a_d = a_q;
                end
                if (ldb) begin
                    b_d = bus_in;
                end else begin
                    b_d = b_q;
                end
                if (start) begin
                    case (op)
                        OP_ADD: begin
                            res_s    = {1'b0, a_q} + {1'b0, b_q};
                            cf_new_s = res_s[W];
                            cmp_s    = 1'b1;
                        end
                        OP_ADC: begin
                            res_s    = {1'b0, a_q} + {1'b0, b_q} + {{W{1'b0}}, cf_q};
                            cf_new_s = res_s[W];
                            cmp_s    = 1'b1;
                        end
                        OP_SUB: begin
                            // Bit W of the 9-bit difference is the borrow (A < B).
                            res_s    = {1'b0, a_q} - {1'b0, b_q};
                            cf_new_s = res_s[W];
                            cmp_s    = 1'b1;
                        end
                        OP_AND: begin
                            res_s = {1'b0, a_q & b_q};
                            cmp_s = 1'b1;
                        end
                        OP_OR: begin
                            res_s = {1'b0, a_q | b_q};
                            cmp_s = 1'b1;
                        end
                        OP_NOT: begin
                            res_s = {1'b0, ~a_q};
                            cmp_s = 1'b1;
                        end
                        OP_INC: begin
                            res_s    = {1'b0, a_q} + {{W{1'b0}}, 1'b1};
                            cf_new_s = res_s[W];
                            cmp_s    = 1'b1;
                        end
                        OP_MUL: begin
`ifdef ALU_MUL_EN
                            state_d = ST_MUL;
                            busy_d  = 1'b1;
                            hi_d    = {W{1'b0}};
                            lo_d    = b_q;
                            cnt_d   = 4'd0;
`else
                            res_s = {1'b0, a_q ^ b_q};
                            cmp_s = 1'b1;
`endif
                        end
                        default: begin
                            cmp_s = 1'b0;
                        end
                    endcase
                end else begin
                    cmp_s = 1'b0;
                end
            end
`ifdef ALU_MUL_EN
            ST_MUL: begin
                if (cnt_q == 4'd8) begin
                    // All eight steps done: {hi,lo} holds A*B. Publish in one edge.
                    res_s    = {1'b0, lo_q};
                    ph_d     = hi_q;
                    cf_new_s = (hi_q != {W{1'b0}});
                    cmp_s    = 1'b1;
                    state_d  = ST_DONE;
                    busy_d   = 1'b0;
                end else begin
                    // One shift-add step; t is untouched so the shifter input stays steady.
                    sum_s = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : {(W+1){1'b0}});
                    hi_d  = sum_s[W:1];
                    lo_d  = {sum_s[0], lo_q[W-1:1]};
                    cnt_d = cnt_q + 4'd1;
                end
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (cmp_s) begin
            t_d    = res_s[W-1:0];
            zf_d   = (res_s[W-1:0] == {W{1'b0}});
            done_d = 1'b1;
        end else begin
            t_d    = t_q;
            zf_d   = zf_q;
            done_d = 1'b0;
        end

        // A shifter carry load wins over the carry produced by a completing op.
        if (ld_cf) begin
            cf_d = shift_cf;
        end else if (cmp_s) begin
            cf_d = cf_new_s;
        end else begin
            cf_d = cf_q;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= {W{1'b0}};
            b_q     <= {W{1'b0}};
            t_q     <= {W{1'b0}};
            cf_q    <= 1'b0;
            zf_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            t_q     <= t_d;
            cf_q    <= cf_d;
            zf_q    <= zf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef ALU_MUL_EN
    // Multiplier working registers and the held product high byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            ph_q  <= {W{1'b0}};
            hi_q  <= {W{1'b0}};
            lo_q  <= {W{1'b0}};
            cnt_q <= 4'd0;
        end else begin
            ph_q  <= ph_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_d;
        end
    end

    assign ph = ph_q;
`else
    assign ph = {W{1'b0}};
`endif

    assign t    = t_q;
    assign busy = busy_q;
    assign done = done_q;
    assign cf   = cf_q;
    assign zf   = zf_q;

endmodule

// File: tb/tb_alu_core.sv
// Directed self-checking bench for alu_core. Covers both builds via ALU_MUL_EN.
module tb_alu_core;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] bus_in;
    logic       lda, ldb;
    logic [2:0] op;
    logic       start;
    logic       shift_cf, ld_cf;
    logic [7:0] t, ph;
    logic       busy, done, cf, zf;

    int total = 0;
    int bad   = 0;
    int cyc;
    int seen;

    alu_core #(.W(8)) dut (
        .clk(clk), .rst(rst), .bus_in(bus_in), .lda(lda), .ldb(ldb),
        .op(op), .start(start), .shift_cf(shift_cf), .ld_cf(ld_cf),
        .t(t), .ph(ph), .busy(busy), .done(done), .cf(cf), .zf(zf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Operand load over two cycles (A then B); returns just after a falling edge.
    task automatic load_ab(input logic [7:0] a, input logic [7:0] b);
        bus_in = a; lda = 1'b1; ldb = 1'b0;
        @(negedge clk);
        bus_in = b; lda = 1'b0; ldb = 1'b1;
        @(negedge clk);
        ldb = 1'b0;
    endtask

    // One-cycle start request; on return the start edge has passed.
    task automatic issue(input logic [2:0] o);
        op = o; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; bus_in = 8'h00; lda = 1'b0; ldb = 1'b0; op = 3'b000;
        start = 1'b0; shift_cf = 1'b0; ld_cf = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_t", {8'h00, t}, 16'h0000);
        chk("rst_ph", {8'h00, ph}, 16'h0000);
        chk("rst_flags", {12'h000, cf, zf, busy, done}, 16'h0000);
        rst = 1'b0;
        @(negedge clk);

        // ADD F0+20
        load_ab(8'hF0, 8'h20);
        issue(3'b000);
        chk("add_t", {8'h00, t}, 16'h0010);
        chk("add_cf_zf", {14'h0000, cf, zf}, 16'h0002);
        chk("add_done_busy", {14'h0000, done, busy}, 16'h0002);
        @(negedge clk);
        chk("add_done_drop", {14'h0000, done, busy}, 16'h0000);

        // ADC 01+01+cf(1)
        load_ab(8'h01, 8'h01);
        issue(3'b001);
        chk("adc_t", {8'h00, t}, 16'h0003);
        chk("adc_cf", {15'h0000, cf}, 16'h0000);

        // SUB equal and borrowing
        load_ab(8'h05, 8'h05);
        issue(3'b010);
        chk("sub_eq", {7'h00, cf, zf, t}, {7'h00, 1'b0, 1'b1, 8'h00});
        load_ab(8'h03, 8'h05);
        issue(3'b010);
        chk("sub_borrow", {7'h00, cf, zf, t}, {7'h00, 1'b1, 1'b0, 8'hFE});

        // Logic ops keep cf (currently 1)
        load_ab(8'hC3, 8'h5A);
        issue(3'b011);
        chk("and", {7'h00, cf, zf, t}, {7'h00, 1'b1, 1'b0, 8'h42});
        issue(3'b100);
        chk("or", {7'h00, cf, zf, t}, {7'h00, 1'b1, 1'b0, 8'hDB});
        issue(3'b101);
        chk("not", {7'h00, cf, zf, t}, {7'h00, 1'b1, 1'b0, 8'h3C});

        // INC wrap, and lda+ldb together
        bus_in = 8'hFF; lda = 1'b1; ldb = 1'b1;
        @(negedge clk);
        lda = 1'b0; ldb = 1'b0;
        issue(3'b110);
        chk("inc_wrap", {7'h00, cf, zf, t}, {7'h00, 1'b1, 1'b1, 8'h00});
        issue(3'b011);
        chk("ldab_both", {8'h00, t}, 16'h00FF);

        // ld_cf alone: cf loads, zf/t untouched
        load_ab(8'hF0, 8'h20);
        issue(3'b000);
        shift_cf = 1'b0; ld_cf = 1'b1;
        @(negedge clk);
        ld_cf = 1'b0;
        chk("ldcf_alone", {7'h00, cf, zf, t}, {7'h00, 1'b0, 1'b0, 8'h10});
        load_ab(8'h05, 8'h05);
        issue(3'b010);
        shift_cf = 1'b1; ld_cf = 1'b1;
        @(negedge clk);
        ld_cf = 1'b0;
        chk("ldcf_keep_zf", {7'h00, cf, zf, t}, {7'h00, 1'b1, 1'b1, 8'h00});

        // ld_cf on the completion edge of ADD: ld_cf wins for cf
        load_ab(8'hF0, 8'h20);
        shift_cf = 1'b0; ld_cf = 1'b1;
        issue(3'b000);
        ld_cf = 1'b0;
        chk("ldcf_prio", {6'h00, done, cf, zf, t}, {6'h00, 1'b1, 1'b0, 1'b0, 8'h10});

`ifdef ALU_MUL_EN
        // MUL 0F*11 = 00FF, latency 9
        load_ab(8'h0F, 8'h11);
        issue(3'b111);
        chk("mul_busy", {14'h0000, busy, done}, 16'h0002);
        chk("mul_t_hold", {8'h00, t}, 16'h0010);
        cyc = 0;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("mul_latency", cyc[15:0], 16'd9);
        chk("mul1_res", {ph, t}, 16'h00FF);
        chk("mul1_flags", {13'h0000, cf, zf, busy}, 16'h0000);

        // MUL FF*FF = FE01 with a start and lda pulsed mid-multiply
        load_ab(8'hFF, 8'hFF);
        issue(3'b111);
        @(negedge clk);
        bus_in = 8'h00; lda = 1'b1; op = 3'b000; start = 1'b1;
        @(negedge clk);
        lda = 1'b0; start = 1'b0;
        cyc = 2;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("mul2_latency", cyc[15:0], 16'd9);
        chk("mul2_res", {ph, t}, 16'hFE01);
        chk("mul2_cf", {14'h0000, cf, zf}, 16'h0002);
        @(negedge clk);
        chk("mul2_done_drop", {14'h0000, done, busy}, 16'h0000);
        issue(3'b110);
        chk("mul2_a_kept", {7'h00, cf, t}, {7'h00, 1'b1, 8'h00});
        chk("ph_held", {8'h00, ph}, 16'h00FE);

        // Reset at cycle 4 of a multiply
        load_ab(8'h0F, 8'h11);
        issue(3'b111);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mulrst_res", {ph, t}, 16'h0000);
        chk("mulrst_flags", {12'h000, cf, zf, busy, done}, 16'h0000);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("mulrst_no_done", seen[15:0], 16'd0);
`else
        // XOR in place of MUL
        load_ab(8'hAA, 8'hFF);
        issue(3'b111);
        chk("xor_t", {8'h00, t}, 16'h0055);
        chk("xor_done", {13'h0000, done, busy, cf}, 16'h0004);
        chk("xor_ph", {8'h00, ph}, 16'h0000);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst2_flags", {4'h0, cf, zf, busy, done, t}, 16'h0000);
`endif

        // Normal ADD after reset
        load_ab(8'h12, 8'h34);
        issue(3'b000);
        chk("post_rst_add", {6'h00, done, cf, zf, t}, {6'h00, 1'b1, 1'b0, 1'b0, 8'h46});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
